// File: rtl/gun_xy_tracker.sv
// gun_xy_tracker: multi-player light-gun position generator.
//
// Converts digital joystick directions (with acceleration on held directions)
// or signed analog stick values (with slew-limited tracking) into clamped
// per-player gun coordinates for the williams2 core's gun_h/gun_v inputs.
//
// Ports:
//   clk_sys      system clock
//   reset_n      asynchronous active-low reset
//   tick         single-cycle movement strobe
//   analog_mode  0 = digital joystick, 1 = analog stick
//   center       single-cycle request to re-center all guns (beats tick)
//   joy_dir      per player {up,down,left,right}, player 0 in [3:0]
//   ana_x/ana_y  per player signed 8-bit stick values, player 0 in [7:0]
//   gun_h/gun_v  per player POS_W-bit coordinates, player 0 in the low bits
//   moving       per player: position changed on the last tick

// One axis engine: acceleration FSM, analog slew and clamped position register.
module gun_xy_axis #(
    parameter int POS_W       = 6,
    parameter int P_MIN       = 0,
    parameter int P_MAX       = 63,
    parameter int ACCEL_TICKS = 8,
    parameter int MAX_STEP    = 4
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    tick,
    input  logic                    analog_mode,
    input  logic                    center,
    input  logic                    dir_pos,
    input  logic                    dir_neg,
    input  logic signed [7:0]       ana,
    output logic [POS_W-1:0]        pos,
    output logic                    changed
);
    // Two guard bits keep old +/- step representable without wrapping.
    localparam int EW    = POS_W + 2;
    localparam int CNT_W = $clog2(ACCEL_TICKS + 1);

    localparam logic signed [EW-1:0] MIN_S  = EW'(P_MIN);
    localparam logic signed [EW-1:0] MAX_S  = EW'(P_MAX);
    localparam logic signed [EW-1:0] STEP_S = EW'(MAX_STEP);
    localparam logic [POS_W-1:0]     MIN_U  = POS_W'(P_MIN);
    localparam logic [POS_W-1:0]     RANGE_U = POS_W'(P_MAX - P_MIN);
    localparam logic [POS_W-1:0]     CTR_U  = POS_W'((P_MIN + P_MAX) / 2);
    localparam logic [CNT_W-1:0]     CNT_END = CNT_W'(ACCEL_TICKS);

    typedef enum logic [1:0] {IDLE, S1, S2, SMAX} accel_e;

    accel_e                  state_q, state_d, state_nxt;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_nxt;
    logic                    dir_q, dir_d, dir_nxt;
    logic [POS_W-1:0]        pos_q, pos_d, pos_nxt;

    logic [7:0]              ana_u;
    logic [POS_W+7:0]        prod;
    logic [POS_W-1:0]        target;
    logic signed [EW-1:0]    pos_s, step, delta;

    function automatic logic [POS_W-1:0] clamp_pos(input logic signed [EW-1:0] v);
        if (v < MIN_S)      return MIN_S[POS_W-1:0];
        else if (v > MAX_S) return MAX_S[POS_W-1:0];
        else                return v[POS_W-1:0];
    endfunction

    function automatic logic signed [EW-1:0] slew_limit(input logic signed [EW-1:0] diff);
        if (diff > STEP_S)       return STEP_S;
        else if (diff < -STEP_S) return -STEP_S;
        else                     return diff;
    endfunction

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        dir_nxt   = dir_q;
        step      = '0;
        delta     = '0;

        // a + 128 for a signed byte is just the sign bit inverted.
        ana_u  = {~ana[7], ana[6:0]};
        prod   = {{POS_W{1'b0}}, ana_u} * {8'd0, RANGE_U};
        target = MIN_U + prod[POS_W+7:8];
        pos_s  = signed'({2'b00, pos_q});

        if (analog_mode) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            delta     = slew_limit(signed'({2'b00, target}) - pos_s);
        end else if (dir_pos ^ dir_neg) begin
            dir_nxt = dir_pos;
            if (state_q == IDLE || dir_pos != dir_q) begin
                // Fresh press or reversal restarts at the slowest speed.
                state_nxt = S1;
                cnt_nxt   = CNT_W'(1);
                step      = EW'(1);
            end else begin
                case (state_q)
                    S1: begin
                        if (cnt_q == CNT_END) begin
                            state_nxt = S2;
                            cnt_nxt   = CNT_W'(1);
                            step      = EW'(2);
                        end else begin
                            cnt_nxt = cnt_q + CNT_W'(1);
                            step    = EW'(1);
                        end
                    end
                    S2: begin
                        if (cnt_q == CNT_END) begin
                            state_nxt = SMAX;
                            cnt_nxt   = CNT_W'(1);
                            step      = STEP_S;
                        end else begin
                            cnt_nxt = cnt_q + CNT_W'(1);
                            step    = EW'(2);
                        end
                    end
                    default: step = STEP_S;
                endcase
            end
            delta = dir_pos ? step : -step;
        end else begin
            // Released or opposing directions: stop without moving.
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end

        pos_nxt = clamp_pos(pos_s + delta);
        changed = (pos_nxt != pos_q);

        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        if (center) begin
            state_d = IDLE;
            cnt_d   = '0;
            pos_d   = CTR_U;
        end else if (tick) begin
            state_d = state_nxt;
            cnt_d   = cnt_nxt;
            dir_d   = dir_nxt;
            pos_d   = pos_nxt;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            pos_q   <= CTR_U;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
        end
    end

    assign pos = pos_q;
endmodule

module gun_xy_tracker #(
    parameter int NUM_PLAYERS = 2,
    parameter int POS_W       = 6,
    parameter int H_MIN       = 0,
    parameter int H_MAX       = 63,
    parameter int V_MIN       = 0,
    parameter int V_MAX       = 63,
    parameter int ACCEL_TICKS = 8,
    parameter int MAX_STEP    = 4
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic                         tick,
    input  logic                         analog_mode,
    input  logic                         center,
    input  logic [4*NUM_PLAYERS-1:0]     joy_dir,
    input  logic [8*NUM_PLAYERS-1:0]     ana_x,
    input  logic [8*NUM_PLAYERS-1:0]     ana_y,
    output logic [POS_W*NUM_PLAYERS-1:0] gun_h,
    output logic [POS_W*NUM_PLAYERS-1:0] gun_v,
    output logic [NUM_PLAYERS-1:0]       moving
);
    logic [NUM_PLAYERS-1:0] chg_h, chg_v;
    logic [NUM_PLAYERS-1:0] moving_q, moving_d;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        // joy_dir nibble: [3]=up, [2]=down, [1]=left, [0]=right.
        gun_xy_axis #(
            .POS_W(POS_W), .P_MIN(H_MIN), .P_MAX(H_MAX),
            .ACCEL_TICKS(ACCEL_TICKS), .MAX_STEP(MAX_STEP)
        ) u_h (
            .clk_sys(clk_sys), .reset_n(reset_n), .tick(tick),
            .analog_mode(analog_mode), .center(center),
            .dir_pos(joy_dir[4*p]), .dir_neg(joy_dir[4*p+1]),
            .ana(ana_x[8*p +: 8]),
            .pos(gun_h[POS_W*p +: POS_W]), .changed(chg_h[p])
        );
        gun_xy_axis #(
            .POS_W(POS_W), .P_MIN(V_MIN), .P_MAX(V_MAX),
            .ACCEL_TICKS(ACCEL_TICKS), .MAX_STEP(MAX_STEP)
        ) u_v (
            .clk_sys(clk_sys), .reset_n(reset_n), .tick(tick),
            .analog_mode(analog_mode), .center(center),
            .dir_pos(joy_dir[4*p+2]), .dir_neg(joy_dir[4*p+3]),
            .ana(ana_y[8*p +: 8]),
            .pos(gun_v[POS_W*p +: POS_W]), .changed(chg_v[p])
        );
    end

    always_comb begin
        moving_d = moving_q;
        if (center)    moving_d = '0;
        else if (tick) moving_d = chg_h | chg_v;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) moving_q <= '0;
        else          moving_q <= moving_d;
    end

    assign moving = moving_q;
endmodule
